// File: rtl/dmem_mmio_uart.sv
// Data-side memory for the single-cycle core: word RAM, TX FIFO and an 8N1 UART transmitter.
// Optional MMIO_CYCLE_COUNTER_EN maps a free-running clk counter at 0x1000_0008.
module dmem_mmio_uart #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- address decode ----------------
  logic [31:0] waddr;
  logic        aligned, ram_hit, txdata_hit, status_hit, store;
  logic        ram_we, push, status_we, err_set;
  logic [AW-1:0] ram_idx;

  assign waddr      = {addr[31:2], 2'b00};
  assign aligned    = (addr[1:0] == 2'b00);
  assign ram_hit    = (addr[31:AW+2] == '0);
  assign txdata_hit = (waddr == TXDATA_ADDR);
  assign status_hit = (waddr == STATUS_ADDR);
  assign ram_idx    = addr[AW+1:2];

  // Stores are ignored entirely while reset is asserted.
  assign store     = memwrite && reset;
  assign ram_we    = store && aligned && ram_hit;
  assign push      = store && aligned && txdata_hit;
  assign status_we = store && aligned && status_hit;
  assign err_set   = store && (!aligned || !(ram_hit || txdata_hit || status_hit));

  logic unused_wd;
  assign unused_wd = ^writedata[31:8];

  // ---------------- RAM ----------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= writedata;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_ok;
  logic          overflow, bus_err;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FW'(1);
      if (pop)     rd_ptr <= rd_ptr + FW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !pop)            overflow <= 1'b1;
      else if (status_we && writedata[3])  overflow <= 1'b0;
      if (err_set)                         bus_err  <= 1'b1;
      else if (status_we && writedata[4])  bus_err  <= 1'b0;
    end
  end

  // ---------------- UART FSM ----------------
  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, baud_end;

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
  assign tx_busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bitn    <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bitn    <= bitn_n;
      shreg   <= shreg_n;
      uart_tx <= tx_n;
    end
  end

  // uart_tx is registered from the level the next state drives.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bitn_n  = bitn;
    shreg_n = shreg;
    tx_n    = 1'b1;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr];
          state_n = S_START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (baud_end) begin
          state_n = S_DATA;
          baud_n  = '0;
          bitn_n  = '0;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      S_DATA: begin
        tx_n = shreg[0];
        if (baud_end) begin
          baud_n = '0;
          if (bitn == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bitn_n  = bitn + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (baud_end) begin
          state_n = S_IDLE;
          baud_n  = '0;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------- read mux ----------------
  logic [31:0] status;
  logic [3:0]  count4;

  assign count4 = 4'(count);
  assign status = {20'h0, count4, 3'b000, bus_err, overflow, tx_busy, empty, full};

`ifdef MMIO_CYCLE_COUNTER_EN
  localparam logic [31:0] CYCLE_ADDR = 32'h1000_0008;
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    readdata = '0;
    if (ram_hit)                  readdata = ram[ram_idx];
    else if (status_hit)          readdata = status;
    else if (waddr == CYCLE_ADDR) readdata = cycle_cnt;
  end
`else
  always_comb begin
    readdata = '0;
    if (ram_hit)         readdata = ram[ram_idx];
    else if (status_hit) readdata = status;
  end
`endif

endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Directed bench for dmem_mmio_uart: RAM, UART framing, FIFO overflow, W1C status, bus errors, reset.
module tb_dmem_mmio_uart;
  localparam int CPB = 4;
  localparam logic [31:0] TXD = 32'h1000_0000;
  localparam logic [31:0] STA = 32'h1000_0004;
  localparam logic [31:0] CYC = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic [31:0] readdata;
  logic        uart_tx, tx_busy;

  int errs = 0;
  int checks = 0;

  dmem_mmio_uart #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .memwrite(memwrite),
    .readdata(readdata), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; #1;
    d = readdata;
  endtask

  // Waits for a start bit, samples mid-bit, and checks the stop bit.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    logic seen;
    seen = 1'b0; ok = 1'b0; b = '0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(posedge clk); #1;
      if (uart_tx === 1'b0) seen = 1'b1;
    end
    if (seen) begin
      repeat (CPB + 2) @(posedge clk);
      #1 b[0] = uart_tx;
      for (int i = 1; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 b[i] = uart_tx;
      end
      repeat (CPB) @(posedge clk);
      #1 ok = (uart_tx === 1'b1);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (uart_tx !== 1'b1) begin errs++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (tx_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    rd(STA, d);
    checks++; if (d !== 32'h0000_0002) begin errs++; $display("FAIL reset_status: got %h want 00000002", d); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_ram;
    logic [31:0] d;
    store(32'h14, 32'hCAFE_F00D);
    store(32'h10, 32'hDEAD_BEEF);
    checks++; if (readdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ram_10: got %h want deadbeef", readdata); end
    rd(32'h14, d);
    checks++; if (d !== 32'hCAFE_F00D) begin errs++; $display("FAIL ram_14: got %h want cafef00d", d); end
    store(32'hFFC, 32'h0BAD_CAFE);
    rd(32'hFFC, d);
    checks++; if (d !== 32'h0BAD_CAFE) begin errs++; $display("FAIL ram_last: got %h want 0badcafe", d); end
  endtask

  task automatic test_tx_frame;
    logic [9:0] fr;
    int         bad;
    fr  = 10'b1_1010_0101_0;   // stop, data 0xA5 msb..lsb, start
    bad = 0;
    store(TXD, 32'h0000_00A5);
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(posedge clk); #1;
      checks++;
      if (uart_tx !== fr[(k - 1) / CPB] || tx_busy !== 1'b1) begin
        errs++; bad++;
        if (bad < 4) $display("FAIL frame_a5 cycle %0d: got tx=%b busy=%b want tx=%b busy=1",
                              k, uart_tx, tx_busy, fr[(k - 1) / CPB]);
      end
    end
    @(posedge clk); #1;
    checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      errs++; $display("FAIL frame_end: got tx=%b busy=%b want tx=1 busy=0", uart_tx, tx_busy);
    end
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] d;
    logic [7:0]  b;
    logic        ok, hi;
    fork
      begin
        for (int i = 0; i < 9; i++) store(TXD, 32'h31 + i);
        rd(STA, d);
        checks++; if (d !== 32'h0000_0805) begin errs++; $display("FAIL fifo_full: got %h want 00000805", d); end
        store(TXD, 32'hEE);
        rd(STA, d);
        checks++; if (d !== 32'h0000_080D) begin errs++; $display("FAIL fifo_ovf: got %h want 0000080d", d); end
      end
      begin
        for (int j = 0; j < 9; j++) begin
          rx_byte(b, ok);
          checks++;
          if (!ok || b !== 8'(8'h31 + j)) begin
            errs++; $display("FAIL rx_byte%0d: got %h ok=%b want %h ok=1", j, b, ok, 8'(8'h31 + j));
          end
        end
      end
    join
    hi = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) hi = 1'b0;
    end
    checks++; if (hi !== 1'b1) begin errs++; $display("FAIL dropped_byte_sent: line went low, want idle"); end
    rd(STA, d);
    checks++; if (d !== 32'h0000_000A) begin errs++; $display("FAIL after_drain: got %h want 0000000a", d); end
  endtask

  task automatic test_w1c;
    logic [31:0] d;
    store(32'h3000_0000, 32'h0);
    rd(STA, d);
    checks++; if (d !== 32'h0000_001A) begin errs++; $display("FAIL w1c_pre: got %h want 0000001a", d); end
    store(STA, 32'h10);
    rd(STA, d);
    checks++; if (d !== 32'h0000_000A) begin errs++; $display("FAIL w1c_buserr_only: got %h want 0000000a", d); end
    store(32'h3000_0000, 32'h0);
    store(STA, 32'h18);
    rd(STA, d);
    checks++; if (d !== 32'h0000_0002) begin errs++; $display("FAIL w1c_both: got %h want 00000002", d); end
  endtask

  task automatic test_bus_err;
    logic [31:0] d;
    store(32'h0, 32'h1234_5678);
    store(32'h2000_0000, 32'hFFFF_FFFF);
    rd(STA, d);
    checks++; if (d !== 32'h0000_0012) begin errs++; $display("FAIL berr_unmapped: got %h want 00000012", d); end
    rd(32'h2000_0000, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL rd_unmapped: got %h want 00000000", d); end
    store(STA, 32'h10);
    store(32'h2, 32'hFFFF_FFFF);
    rd(STA, d);
    checks++; if (d !== 32'h0000_0012) begin errs++; $display("FAIL berr_misalign: got %h want 00000012", d); end
    rd(32'h2, d);
    checks++; if (d !== 32'h1234_5678) begin errs++; $display("FAIL rd_misalign: got %h want 12345678", d); end
    store(STA, 32'h10);
    store(32'h1000, 32'hFFFF_FFFF);
    rd(32'h0, d);
    checks++; if (d !== 32'h1234_5678) begin errs++; $display("FAIL ram_alias: got %h want 12345678", d); end
    rd(STA, d);
    checks++; if (d !== 32'h0000_0012) begin errs++; $display("FAIL berr_past_ram: got %h want 00000012", d); end
    rd(TXD, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL rd_txdata: got %h want 00000000", d); end
    store(STA, 32'h10);
    store(CYC, 32'h5);
    rd(STA, d);
    checks++; if (d !== 32'h0000_0012) begin errs++; $display("FAIL berr_cycle: got %h want 00000012", d); end
`ifndef MMIO_CYCLE_COUNTER_EN
    rd(CYC, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL rd_cycle_unmapped: got %h want 00000000", d); end
`endif
    store(STA, 32'h18);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        hi;
    store(TXD, 32'h55);
    store(TXD, 32'h66);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (tx_busy !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b want 1", tx_busy); end
    @(negedge clk);
    reset = 1'b0; addr = TXD; writedata = 32'h77; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
    checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      errs++; $display("FAIL mid_reset: got tx=%b busy=%b want tx=1 busy=0", uart_tx, tx_busy);
    end
    @(negedge clk);
    addr = TXD; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
    rd(STA, d);
    checks++; if (d !== 32'h0000_0002) begin errs++; $display("FAIL mid_status: got %h want 00000002", d); end
`ifdef MMIO_CYCLE_COUNTER_EN
    rd(CYC, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL cycle_reset: got %h want 00000000", d); end
`endif
    @(negedge clk) reset = 1'b1;
`ifdef MMIO_CYCLE_COUNTER_EN
    @(posedge clk); #1;
    rd(CYC, d);
    checks++; if (d !== 32'h1) begin errs++; $display("FAIL cycle_1: got %h want 00000001", d); end
    @(posedge clk); #1;
    rd(CYC, d);
    checks++; if (d !== 32'h2) begin errs++; $display("FAIL cycle_2: got %h want 00000002", d); end
`endif
    hi = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) hi = 1'b0;
    end
    checks++; if (hi !== 1'b1) begin errs++; $display("FAIL post_reset_idle: line or busy active, want idle"); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_tx_frame;
    test_fifo_overflow;
    test_w1c;
    test_bus_err;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
